// File: rtl/player.sv
// Dual-clock playback buffer: host fills memory on h_clk, samples stream out on w_clk
// once or in a loop after w_reset_n is released, with a done flag mirrored to h_clk.
module player #(
    parameter int width    = 8,
    parameter int timeBits = 10
) (
    input  logic                w_clk,
    input  logic                w_reset_n,
    input  logic [timeBits:0]   w_length,
    input  logic                w_loop,
    output logic [width-1:0]    w_out,
    output logic                w_valid,
    output logic [timeBits-1:0] w_pos,
    output logic                w_done,
    input  logic                h_clk,
    input  logic                h_write,
    input  logic [timeBits-1:0] h_addr,
    input  logic [width-1:0]    h_data,
    output logic                h_done
);

    localparam int DEPTH = 1 << timeBits;
    localparam logic [timeBits:0] DEPTH_L = (timeBits + 1)'(DEPTH);
    localparam logic [timeBits:0] ONE     = (timeBits + 1)'(1);

    localparam logic [1:0] ST_ARM   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [width-1:0]    mem [DEPTH];
    logic [1:0]          state;
    logic [timeBits:0]   cursor;
    logic [timeBits:0]   len_q;
    logic                loop_q;
    logic [timeBits:0]   len_eff;
    logic                rd_en;
    logic                last_rd;
    logic [width-1:0]    rd_p0;
    logic [timeBits-1:0] pos_p0;
    logic                vld_p0;
    logic                h_sync_p0;
    logic                h_sync_p1;

    always_ff @(posedge h_clk) begin
        if (h_write) begin
            mem[h_addr] <= h_data;
        end
    end

    // A zero or oversized length means "the whole memory".
    always_comb begin
        len_eff = len_q;
        if (len_q == '0 || len_q > DEPTH_L) begin
            len_eff = DEPTH_L;
        end
    end

    assign rd_en   = (state == ST_ARM) || (state == ST_RUN);
    assign last_rd = (cursor == len_eff - ONE);

    // Stage p0: memory read register; cursor is always below len_eff, so its low bits address mem
    always_ff @(posedge w_clk) begin
        rd_p0  <= mem[cursor[timeBits-1:0]];
        pos_p0 <= cursor[timeBits-1:0];
    end

    // Stage p1: output register plus playback control
    always_ff @(posedge w_clk) begin
        if (!w_reset_n) begin
            state   <= ST_ARM;
            cursor  <= '0;
            len_q   <= w_length;
            loop_q  <= w_loop;
            vld_p0  <= 1'b0;
            w_valid <= 1'b0;
            w_done  <= 1'b0;
            w_out   <= '0;
            w_pos   <= '0;
        end else begin
            vld_p0 <= rd_en;
            if (rd_en) begin
                if (last_rd) begin
                    cursor <= '0;
                    state  <= loop_q ? ST_RUN : ST_DRAIN;
                end else begin
                    cursor <= cursor + ONE;
                    state  <= ST_RUN;
                end
            end
            if (vld_p0) begin
                w_valid <= 1'b1;
                w_out   <= rd_p0;
                w_pos   <= pos_p0;
            end else if (state == ST_DRAIN) begin
                w_valid <= 1'b0;
                w_done  <= 1'b1;
                state   <= ST_DONE;
            end
        end
    end

    always_ff @(posedge h_clk) begin
        h_sync_p0 <= w_done;
        h_sync_p1 <= h_sync_p0;
    end

    assign h_done = h_sync_p1;

endmodule

// File: tb/tb_player.sv
// Randomised scoreboard bench for player: a reference model predicts each played sample,
// a monitor pops and compares whenever w_valid is high.
module tb_player;

    localparam int W  = 8;
    localparam int TB = 4;
    localparam int D  = 1 << TB;

    logic          w_clk = 1'b0;
    logic          h_clk = 1'b0;
    logic          w_reset_n;
    logic [TB:0]   w_length;
    logic          w_loop;
    logic [W-1:0]  w_out;
    logic          w_valid;
    logic [TB-1:0] w_pos;
    logic          w_done;
    logic          h_write;
    logic [TB-1:0] h_addr;
    logic [W-1:0]  h_data;
    logic          h_done;

    typedef struct {
        int         pos;
        logic [7:0] data;
        bit         any;
        logic [7:0] alt;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl_mem[D];
    int         total = 0;
    int         bad   = 0;

    player #(.width(W), .timeBits(TB)) dut (
        .w_clk(w_clk), .w_reset_n(w_reset_n), .w_length(w_length), .w_loop(w_loop),
        .w_out(w_out), .w_valid(w_valid), .w_pos(w_pos), .w_done(w_done),
        .h_clk(h_clk), .h_write(h_write), .h_addr(h_addr), .h_data(h_data), .h_done(h_done)
    );

    always #5 w_clk = ~w_clk;
    always #7 h_clk = ~h_clk;

    // Monitor: every played sample must match the head of the scoreboard.
    always @(negedge w_clk) begin
        if (w_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid got pos=%0d data=%h, wanted no sample", w_pos, w_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ((int'(w_pos) != e.pos) ||
                    !((w_out === e.data) || (e.any && w_out === e.alt))) begin
                    bad++;
                    $display("FAIL sample got pos=%0d data=%h, wanted pos=%0d data=%h", w_pos, w_out, e.pos, e.data);
                end
            end
            total++;
            if (w_done !== 1'b0) begin
                bad++;
                $display("FAIL valid_with_done got w_done=%b, wanted 0", w_done);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int len_eff_f(input int len);
        return (len == 0 || len > D) ? D : len;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        @(negedge h_clk);
        h_write = 1'b1;
        h_addr  = TB'(a);
        h_data  = d;
        @(negedge h_clk);
        h_write = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic push_run(input int len, input int count);
        int le;
        exp_t e;
        le = len_eff_f(len);
        for (int k = 0; k < count; k++) begin
            e.pos  = k % le;
            e.data = mdl_mem[k % le];
            e.any  = 1'b0;
            e.alt  = 8'h00;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge w_clk);
            #1;
            n++;
        end while (sb.size() != 0 && n < max_cyc);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got %0d pending samples, wanted 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_hdone(input logic want);
        int n;
        n = 0;
        while (h_done !== want && n < 5) begin
            @(negedge h_clk);
            n++;
        end
        chk("h_done", 32'(h_done), 32'(want));
    endtask

    task automatic arm(input int len, input logic lp);
        w_reset_n = 1'b0;
        w_length  = (TB + 1)'(len);
        w_loop    = lp;
        @(posedge w_clk);
        @(negedge w_clk);
    endtask

    task automatic run_oneshot(input int len, input bit change_params);
        int le;
        int n;
        le = len_eff_f(len);
        arm(len, 1'b0);
        push_run(len, le);
        w_reset_n = 1'b1;
        if (change_params) begin
            w_length = (TB + 1)'(2);
            w_loop   = 1'b1;
        end
        wait_drain(le + 20, n);
        chk("oneshot_latency", 32'(n), 32'(le + 1));
        @(negedge w_clk);
        chk("end_valid", 32'(w_valid), 32'd0);
        chk("end_done", 32'(w_done), 32'd1);
        chk("end_out", 32'(w_out), 32'(mdl_mem[le-1]));
        chk("end_pos", 32'(w_pos), 32'(le - 1));
        wait_hdone(1'b1);
    endtask

    task automatic run_loop(input int len, input int count);
        int n;
        arm(len, 1'b1);
        push_run(len, count);
        w_reset_n = 1'b1;
        wait_drain(count + 20, n);
        chk("loop_latency", 32'(n), 32'(count + 1));
        chk("loop_still_valid", 32'(w_valid), 32'd1);
        chk("loop_no_done", 32'(w_done), 32'd0);
        w_reset_n = 1'b0;
        @(negedge w_clk);
        chk("loop_stop_valid", 32'(w_valid), 32'd0);
    endtask

    initial begin
        int n;
        exp_t e;
        w_reset_n = 1'b0;
        w_length  = '0;
        w_loop    = 1'b0;
        h_write   = 1'b0;
        h_addr    = '0;
        h_data    = '0;
        for (int i = 0; i < D; i++) begin
            host_write(i, (i < 8) ? 8'(i + 8'h10) : 8'($urandom));
        end
        repeat (3) @(posedge w_clk);
        @(negedge w_clk);
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_out", 32'(w_out), 32'd0);
        chk("rst_pos", 32'(w_pos), 32'd0);
        chk("rst_done", 32'(w_done), 32'd0);
        wait_hdone(1'b0);

        // One-shot of length 4, then h_done must clear after re-arm
        run_oneshot(4, 1'b0);
        arm(4, 1'b0);
        wait_hdone(1'b0);

        run_loop(3, 11);

        run_oneshot(0, 1'b0);
        run_oneshot(17, 1'b0);

        // Reset at the third valid sample
        arm(8, 1'b0);
        push_run(8, 3);
        w_reset_n = 1'b1;
        wait_drain(30, n);
        w_reset_n = 1'b0;
        @(negedge w_clk);
        chk("mid_valid", 32'(w_valid), 32'd0);
        chk("mid_out", 32'(w_out), 32'd0);
        chk("mid_done", 32'(w_done), 32'd0);
        chk("mid_pos", 32'(w_pos), 32'd0);
        run_oneshot(2, 1'b0);

        // Rewrite mem[2] during a length-4 loop
        arm(4, 1'b1);
        for (int k = 0; k < 12; k++) begin
            e.pos  = k % 4;
            e.data = mdl_mem[k % 4];
            e.any  = (e.pos == 2) && (k >= 4) && (k < 8);
            e.alt  = 8'hAA;
            if (e.pos == 2 && k >= 8) e.data = 8'hAA;
            sb.push_back(e);
        end
        w_reset_n = 1'b1;
        n = 0;
        while (sb.size() > 8 && n < 30) begin
            @(negedge w_clk);
            #1;
            n++;
        end
        host_write(2, 8'hAA);
        wait_drain(40, n);
        chk("wr_loop_no_done", 32'(w_done), 32'd0);
        w_reset_n = 1'b0;
        @(negedge w_clk);

        // Parameters changed while running must be ignored
        run_oneshot(5, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int len;
            host_write($urandom_range(0, D - 1), 8'($urandom));
            len = $urandom_range(0, D + 4);
            if ($urandom_range(0, 1) == 1) run_loop(len, len_eff_f(len) + $urandom_range(1, 20));
            else run_oneshot(len, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
